mips_booth_mult_unit: RTL and testbench

- Parametrised, iterative Booth multiplier for the pipelined MIPS core. Executes MULT and MULTU for the execute stage.
- Accepts one operation through a start/busy/done handshake and produces a 2*WIDTH product as hi/lo words.
- Exposes a stall request to the hazard logic.
- Supports pipeline flush (abort) and signed/unsigned mode. The current core has neither a multiplier nor flush capability.

---
 rtl/mips_booth_mult_unit.sv | 149 ++++++++++++++
 tb/tb_mips_booth_mult_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mips_booth_mult_unit.sv
// Iterative Booth multiplier (MULT/MULTU); radix-2, or radix-4 when BOOTH_RADIX4_EN is defined.
// Latency WIDTH+1 steps (radix-4: (WIDTH+2)/2), then a one-cycle done; start is ignored while busy.
module mips_booth_mult_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

`ifdef BOOTH_RADIX4_EN
  localparam int EW   = WIDTH + 2;
  localparam int AW   = WIDTH + 3;
  localparam int ITER = (WIDTH + 2) / 2;
`else
  localparam int EW   = WIDTH + 1;
  localparam int AW   = WIDTH + 1;
  localparam int ITER = WIDTH + 1;
`endif
  localparam int PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ITER);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    m_q, m_d;
  logic [AW-1:0]    a_q, a_d;
  logic [EW-1:0]    q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [AW-1:0]    pp;
  logic [AW-1:0]    sum;
  logic [AW-1:0]    a_n;
  logic [EW-1:0]    q_n;
  logic             qm1_n;

  // One Booth step on the current {A,Q,Q_-1}.
  always_comb begin
    pp = '0;
`ifdef BOOTH_RADIX4_EN
    case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: pp = m_q;
      3'b011:         pp = m_q << 1;
      3'b100:         pp = -(m_q << 1);
      3'b101, 3'b110: pp = -m_q;
      default:        pp = '0;
    endcase
    sum   = a_q + pp;
    a_n   = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_n   = {sum[1:0], q_q[EW-1:2]};
    qm1_n = q_q[1];
`else
    case ({q_q[0], qm1_q})
      2'b01:   pp = m_q;
      2'b10:   pp = -m_q;
      default: pp = '0;
    endcase
    sum   = a_q + pp;
    a_n   = {sum[AW-1], sum[AW-1:1]};
    q_n   = {sum[0], q_q[EW-1:1]};
    qm1_n = q_q[0];
`endif
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          // Extending to AW bits directly equals extending to EW then sign-extending.
          m_d     = {{(AW-WIDTH){is_signed & op_a[WIDTH-1]}}, op_a};
          q_d     = {{(EW-WIDTH){is_signed & op_b[WIDTH-1]}}, op_b};
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = CNT_INIT;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          a_d   = a_n;
          q_d   = q_n;
          qm1_d = qm1_n;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d      = S_DONE;
            {hi_d, lo_d} = PW'({a_n, q_n});
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign stall_req = busy | (start & (state_q == S_IDLE));
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_mips_booth_mult_unit.sv
// Directed bench for mips_booth_mult_unit with hand-computed products.
module tb_mips_booth_mult_unit;

`ifdef BOOTH_RADIX4_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 33;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic        flush;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        stall_req;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  mips_booth_mult_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .flush     (flush),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble the inputs after acceptance, and check timing and result.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [31:0] eh, input logic [31:0] el, input string tag);
    int busy_n;
    int waited;
    @(negedge clk);
    op_a = a; op_b = b; is_signed = sgn; start = 1'b1;
    #1;
    check({tag, "/stall"}, {63'd0, stall_req}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; is_signed = ~sgn;
    busy_n = 0;
    waited = 0;
    while (!done && waited < 200) begin
      if (busy) busy_n++;
      @(negedge clk);
      waited++;
    end
    check({tag, "/done"}, {63'd0, done}, 64'd1);
    check({tag, "/busy_cycles"}, 64'(busy_n), 64'(LAT));
    check({tag, "/hi"}, {32'd0, hi}, {32'd0, eh});
    check({tag, "/lo"}, {32'd0, lo}, {32'd0, el});
    @(negedge clk);
    check({tag, "/done_one_cycle"}, {63'd0, done}, 64'd0);
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    int dn;
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; flush = 1'b0;
    op_a = '0; op_b = '0;
    #12;
    check("rst/busy", {63'd0, busy}, 64'd0);
    check("rst/done", {63'd0, done}, 64'd0);
    check("rst/stall", {63'd0, stall_req}, 64'd0);
    check("rst/hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'd3, 32'd5, 1'b1, 32'h0000_0000, 32'h0000_000F, "s3x5");
    run_op(32'hFFFF_FFF9, 32'd6, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFD6, "sneg7x6");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000, "sminxmin");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, "umaxxmax");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001, "sm1xm1");

    // Flush mid-run: previous 3*5 result must survive.
    run_op(32'd3, 32'd5, 1'b1, 32'h0, 32'hF, "pre_flush");
    @(negedge clk);
    op_a = 32'd9; op_b = 32'd9; is_signed = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("flush/busy_before", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush/busy_after", {63'd0, busy}, 64'd0);
    check("flush/done_after", {63'd0, done}, 64'd0);
    check("flush/hilo_kept", {hi, lo}, 64'h0000_0000_0000_000F);
    count_done(40, dn);
    check("flush/no_done", 64'(dn), 64'd0);
    run_op(32'd2, 32'd2, 1'b0, 32'h0, 32'h4, "post_flush");

    // start while running is ignored.
    @(negedge clk);
    op_a = 32'd3; op_b = 32'd5; is_signed = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    op_a = 32'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    count_done(LAT + 20, dn);
    check("ign/done_count", 64'(dn), 64'd1);
    check("ign/hilo", {hi, lo}, 64'h0000_0000_0000_000F);
    check("ign/idle", {63'd0, busy}, 64'd0);

    // flush and start on the same IDLE edge: not accepted.
    @(negedge clk);
    op_a = 32'd5; op_b = 32'd5; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flushstart/busy", {63'd0, busy}, 64'd0);
    count_done(LAT + 10, dn);
    check("flushstart/no_done", 64'(dn), 64'd0);
    check("flushstart/hilo", {hi, lo}, 64'h0000_0000_0000_000F);

    // Asynchronous reset between edges in the middle of a run.
    @(negedge clk);
    op_a = 32'd7; op_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("arst/busy_before", {63'd0, busy}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst/busy", {63'd0, busy}, 64'd0);
    check("arst/done", {63'd0, done}, 64'd0);
    check("arst/hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(LAT + 10, dn);
    check("arst/no_done", 64'(dn), 64'd0);
    run_op(32'd3, 32'd5, 1'b1, 32'h0, 32'hF, "post_arst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
